xillybus_loopback_fifo_32: RTL

- Synchronous 32-bit FIFO on the user side of the Xillybus core, directly downstream of the user_w_write_32 stream and upstream of user_r_read_32.
- Data the host writes to the 32-bit write device file is buffered and returned on the 32-bit read device file.
- Generates the read-side EOF when the host closes the write file and the FIFO has drained.
- Flushes all stored data when the host closes the read file.

---
 rtl/xillybus_loopback_fifo_32.sv | 130 +++++++++++++
 1 files changed

// File: rtl/xillybus_loopback_fifo_32.sv
// Loopback FIFO between the Xillybus 32-bit write and read streams: buffers host
// writes for the read file, raises EOF once the write file is closed and drained.
module xillybus_loopback_fifo_32 #(
    parameter int DEPTH = 512,
    parameter int AW    = 9
) (
    input  logic          bus_clk,
    input  logic          reset,
    input  logic          user_w_write_32_wren,
    input  logic [31:0]   user_w_write_32_data,
    output logic          user_w_write_32_full,
    input  logic          user_w_write_32_open,
    input  logic          user_r_read_32_rden,
    output logic [31:0]   user_r_read_32_data,
    output logic          user_r_read_32_empty,
    output logic          user_r_read_32_eof,
    input  logic          user_r_read_32_open,
    output logic [AW:0]   fill_level,
    output logic          overflow_err,
    output logic          underflow_err
);

    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   COUNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE    = {{(AW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_OPEN   = 2'd1,
        S_CLOSED = 2'd2
    } session_t;

    // Session state is kept as a named signal so checkers can bind to it.
    session_t session_state;
    session_t session_next;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    logic          wo_q;
    logic          ro_q;
    logic          flush;
    logic          wr_ok;
    logic          rd_ok;

    // Handshake: a write is taken on wren while full is low, a read on rden while
    // empty is low; strobes against the flag are dropped and flagged as errors.
    // Closing the read file wins over both strobes for that cycle.
    assign flush = ro_q & ~user_r_read_32_open;
    assign wr_ok = user_w_write_32_wren & ~user_w_write_32_full & ~flush;
    assign rd_ok = user_r_read_32_rden & ~user_r_read_32_empty & ~flush;
    assign fill_level = count;

    always_comb begin
        count_next = count;
        if (flush)
            count_next = '0;
        else if (wr_ok & ~rd_ok)
            count_next = count + COUNT_ONE;
        else if (rd_ok & ~wr_ok)
            count_next = count - COUNT_ONE;
    end

    always_ff @(posedge bus_clk) begin
        if (wr_ok)
            mem[wr_ptr] <= user_w_write_32_data;
    end

    always_ff @(posedge bus_clk or posedge reset) begin
        if (reset) begin
            wr_ptr               <= '0;
            rd_ptr               <= '0;
            count                <= '0;
            user_w_write_32_full <= 1'b0;
            user_r_read_32_empty <= 1'b1;
            user_r_read_32_data  <= '0;
            user_r_read_32_eof   <= 1'b0;
            overflow_err         <= 1'b0;
            underflow_err        <= 1'b0;
            wo_q                 <= 1'b0;
            ro_q                 <= 1'b0;
        end else begin
            count                <= count_next;
            user_w_write_32_full <= (count_next == FULL_COUNT);
            user_r_read_32_empty <= (count_next == '0);
            wo_q                 <= user_w_write_32_open;
            ro_q                 <= user_r_read_32_open;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr_ok)
                    wr_ptr <= wr_ptr + PTR_ONE;
                if (rd_ok)
                    rd_ptr <= rd_ptr + PTR_ONE;
                if (user_w_write_32_wren & user_w_write_32_full)
                    overflow_err <= 1'b1;
                if (user_r_read_32_rden & user_r_read_32_empty)
                    underflow_err <= 1'b1;
            end
            if (rd_ok)
                user_r_read_32_data <= mem[rd_ptr];
            user_r_read_32_eof <= ~flush & (session_state == S_CLOSED) &
                                  user_r_read_32_empty & user_r_read_32_open;
        end
    end

    always_ff @(posedge bus_clk or posedge reset) begin
        if (reset)
            session_state <= S_IDLE;
        else
            session_state <= session_next;
    end

    // Open/close edges are judged against the registered copy of write_open.
    always_comb begin
        session_next = session_state;
        case (session_state)
            S_IDLE:   if (user_w_write_32_open) session_next = S_OPEN;
            S_OPEN:   if (wo_q & ~user_w_write_32_open) session_next = S_CLOSED;
            S_CLOSED: if (~wo_q & user_w_write_32_open) session_next = S_OPEN;
            default:  session_next = S_IDLE;
        endcase
        if (flush)
            session_next = S_IDLE;
    end

endmodule
